keyboard_scanner: RTL and testbench

KEYBOARD_SCANNER -- requirements
Module: keyboard_scanner

---
 rtl/keyboard_scanner_pkg.sv | 17 +
 rtl/keyboard_scanner_if.sv | 22 ++
 rtl/keyboard_scanner_debouncer.sv | 49 ++++
 rtl/keyboard_scanner.sv | 144 ++++++++++++++
 tb/tb_keyboard_scanner.sv | 278 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/keyboard_scanner_pkg.sv
// Shared keypad geometry, vector type and column-drive helper for the keyboard scanner.
package keyboard_scanner_pkg;

    localparam int unsigned KEYBOARD_ROW_COUNT = 4;
    localparam int unsigned KEYBOARD_COL_COUNT = 4;
    localparam int unsigned KEYBOARD_COUNT     = KEYBOARD_ROW_COUNT * KEYBOARD_COL_COUNT;
    localparam int unsigned COL_W              = 2;
    localparam int unsigned STABLE_W           = 4;

    typedef logic [KEYBOARD_COUNT-1:0] key_vec_t;

    // Active-low one-hot drive pattern for a column index
    function automatic logic [KEYBOARD_COL_COUNT-1:0] col_drive(input logic [COL_W-1:0] col);
        return ~(4'b0001 << col);
    endfunction

endpackage

// File: rtl/keyboard_scanner_if.sv
// Keypad matrix lines plus the published-vector handshake between scanner and consumer.
interface keyboard_scanner_if;
    import keyboard_scanner_pkg::*;

    logic [KEYBOARD_ROW_COUNT-1:0] kb_row;
    logic [KEYBOARD_COL_COUNT-1:0] kb_col;
    key_vec_t                      keys;
    logic                          key_valid;
    logic                          key_ack;
    logic                          overrun;

    modport master (
        input  kb_row, key_ack,
        output kb_col, keys, key_valid, overrun
    );

    modport slave (
        output kb_row, key_ack,
        input  kb_col, keys, key_valid, overrun
    );

endinterface

// File: rtl/keyboard_scanner_debouncer.sv
// Frame debouncer: publishes a frame once it has been seen DEBOUNCE_FRAMES times in a row.
module keyboard_debouncer
    import keyboard_scanner_pkg::*;
#(
    parameter int unsigned DEBOUNCE_FRAMES = 3
) (
    input  logic     clk_ctrl,
    input  logic     reset,
    input  key_vec_t frame,
    input  logic     commit,
    input  key_vec_t keys,
    output logic     publish_c,
    output key_vec_t stable_frame_c
);

    localparam logic [STABLE_W-1:0] CNT_MAX = STABLE_W'(DEBOUNCE_FRAMES);

    key_vec_t            last_frame;
    key_vec_t            last_frame_n;
    logic [STABLE_W-1:0] stable_cnt;
    logic [STABLE_W-1:0] stable_cnt_n;

    // Run-length of identical frames, saturating at the threshold
    always_comb begin
        last_frame_n = last_frame;
        stable_cnt_n = stable_cnt;
        if (commit) begin
            if (frame == last_frame) begin
                stable_cnt_n = (stable_cnt >= CNT_MAX) ? CNT_MAX : stable_cnt + STABLE_W'(1);
            end else begin
                last_frame_n = frame;
                stable_cnt_n = STABLE_W'(1);
            end
        end
        publish_c      = commit && (stable_cnt_n == CNT_MAX) && (frame != keys);
        stable_frame_c = last_frame_n;
    end

    always_ff @(posedge clk_ctrl or posedge reset) begin
        if (reset) begin
            last_frame <= '1;
            stable_cnt <= '0;
        end else begin
            last_frame <= last_frame_n;
            stable_cnt <= stable_cnt_n;
        end
    end

endmodule

// File: rtl/keyboard_scanner.sv
// 4x4 keypad column scanner with change-event handshake and overrun flag.
// Define KEYBOARD_DEBOUNCE_EN to require several identical frames before publishing.
module keyboard_scanner
    import keyboard_scanner_pkg::*;
#(
    parameter int unsigned SCAN_DIV        = 4,
    parameter int unsigned DEBOUNCE_FRAMES = 3
) (
    input  logic                clk_ctrl,
    input  logic                reset,
    keyboard_scanner_if.master  bus
);

    localparam int unsigned DIV_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);

    localparam logic [1:0] ST_SETTLE = 2'd0;
    localparam logic [1:0] ST_SAMPLE = 2'd1;
    localparam logic [1:0] ST_COMMIT = 2'd2;

    generate
        if (SCAN_DIV < 2 || DEBOUNCE_FRAMES < 1 || DEBOUNCE_FRAMES > 15) begin : g_bad_cfg
            $error("keyboard_scanner: SCAN_DIV or DEBOUNCE_FRAMES out of range");
        end
    endgenerate

    logic [1:0]       state, state_n;
    logic [COL_W-1:0] col, col_n;
    logic [DIV_W-1:0] div_cnt, div_cnt_n;
    logic [3:0]       kb_col_q, kb_col_n;
    key_vec_t         frame, frame_n;
    key_vec_t         keys_q, keys_n;
    logic             valid_q, valid_n;
    logic             ovr_q, ovr_n;
    logic             commit_c;
    logic             publish_c;
    key_vec_t         pub_vec_c;

    assign commit_c = (state == ST_COMMIT);

`ifdef KEYBOARD_DEBOUNCE_EN
    keyboard_debouncer #(
        .DEBOUNCE_FRAMES (DEBOUNCE_FRAMES)
    ) u_debouncer (
        .clk_ctrl       (clk_ctrl),
        .reset          (reset),
        .frame          (frame),
        .commit         (commit_c),
        .keys           (keys_q),
        .publish_c      (publish_c),
        .stable_frame_c (pub_vec_c)
    );
`else
    assign publish_c = commit_c && (frame != keys_q);
    assign pub_vec_c = frame;
`endif

    // Scan sequencing, frame capture and event handshake
    always_comb begin
        state_n   = state;
        col_n     = col;
        div_cnt_n = div_cnt;
        kb_col_n  = kb_col_q;
        frame_n   = frame;
        keys_n    = keys_q;
        valid_n   = valid_q;
        ovr_n     = ovr_q;

        case (state)
            ST_SETTLE: begin
                if (div_cnt == DIV_LAST) begin
                    state_n   = ST_SAMPLE;
                    div_cnt_n = '0;
                end else begin
                    div_cnt_n = div_cnt + DIV_W'(1);
                end
            end
            ST_SAMPLE: begin
                frame_n[{col, 2'b00} +: 4] = bus.kb_row;
                if (col == COL_W'(KEYBOARD_COL_COUNT - 1)) begin
                    state_n  = ST_COMMIT;
                    kb_col_n = 4'hF;
                end else begin
                    state_n  = ST_SETTLE;
                    col_n    = col + COL_W'(1);
                    kb_col_n = col_drive(col + COL_W'(1));
                end
            end
            ST_COMMIT: begin
                state_n  = ST_SETTLE;
                col_n    = '0;
                kb_col_n = col_drive('0);
            end
            default: begin
                state_n   = ST_SETTLE;
                col_n     = '0;
                div_cnt_n = '0;
                kb_col_n  = col_drive('0);
            end
        endcase

        // A same-edge publish keeps the event pending; an unacked one is an overrun
        if (publish_c) begin
            keys_n  = pub_vec_c;
            valid_n = 1'b1;
            if (valid_q && !bus.key_ack) begin
                ovr_n = 1'b1;
            end else if (valid_q && bus.key_ack) begin
                ovr_n = 1'b0;
            end
        end else if (valid_q && bus.key_ack) begin
            valid_n = 1'b0;
            ovr_n   = 1'b0;
        end
    end

    always_ff @(posedge clk_ctrl or posedge reset) begin
        if (reset) begin
            state    <= ST_SETTLE;
            col      <= '0;
            div_cnt  <= '0;
            kb_col_q <= 4'b1110;
            frame    <= '1;
            keys_q   <= '1;
            valid_q  <= 1'b0;
            ovr_q    <= 1'b0;
        end else begin
            state    <= state_n;
            col      <= col_n;
            div_cnt  <= div_cnt_n;
            kb_col_q <= kb_col_n;
            frame    <= frame_n;
            keys_q   <= keys_n;
            valid_q  <= valid_n;
            ovr_q    <= ovr_n;
        end
    end

    assign bus.kb_col    = kb_col_q;
    assign bus.keys      = keys_q;
    assign bus.key_valid = valid_q;
    assign bus.overrun   = ovr_q;

endmodule

// File: tb/tb_keyboard_scanner.sv
// Self-checking bench for keyboard_scanner: keypad matrix model plus frame-level reference model.
module tb_keyboard_scanner;
    import keyboard_scanner_pkg::*;

    localparam int unsigned SCAN_DIV        = 4;
    localparam int unsigned DEBOUNCE_FRAMES = 3;
`ifdef KEYBOARD_DEBOUNCE_EN
    localparam int D_EFF = DEBOUNCE_FRAMES;
`else
    localparam int D_EFF = 1;
`endif
    localparam int FRAME_CYC = 4 * (SCAN_DIV + 1) + 1;

    logic clk_ctrl = 1'b0;
    logic reset    = 1'b1;
    always #5 clk_ctrl = ~clk_ctrl;

    keyboard_scanner_if bus();
    logic [15:0] matrix = 16'hFFFF;

    // Pressed keys pull their row low only while their column is driven
    function automatic logic [3:0] row_lines(input logic [3:0] kc, input logic [15:0] m);
        case (kc)
            4'hE:    return m[3:0];
            4'hD:    return m[7:4];
            4'hB:    return m[11:8];
            4'h7:    return m[15:12];
            default: return 4'hF;
        endcase
    endfunction

    assign bus.kb_row = row_lines(bus.kb_col, matrix);

    keyboard_scanner #(
        .SCAN_DIV        (SCAN_DIV),
        .DEBOUNCE_FRAMES (DEBOUNCE_FRAMES)
    ) dut (
        .clk_ctrl (clk_ctrl),
        .reset    (reset),
        .bus      (bus)
    );

    int checks   = 0;
    int failures = 0;

    logic [15:0] hist[$];
    logic [15:0] exp_keys;
    logic        exp_valid;
    logic        exp_ovr;

    task automatic model_reset();
        hist.delete();
        exp_keys  = 16'hFFFF;
        exp_valid = 1'b0;
        exp_ovr   = 1'b0;
    endtask

    function automatic int trailing_run();
        int n = 0;
        for (int i = hist.size() - 1; i >= 0; i--) begin
            if (hist[i] == hist[hist.size() - 1]) n++;
            else break;
        end
        return n;
    endfunction

    task automatic model_commit(input logic [15:0] f, input bit ack);
        bit pub;
        hist.push_back(f);
        if (hist.size() > 32) void'(hist.pop_front());
        pub = (trailing_run() >= D_EFF) && (f != exp_keys);
        if (pub) begin
            if (exp_valid && !ack) exp_ovr = 1'b1;
            else if (exp_valid && ack) exp_ovr = 1'b0;
            exp_keys  = f;
            exp_valid = 1'b1;
        end else if (exp_valid && ack) begin
            exp_valid = 1'b0;
            exp_ovr   = 1'b0;
        end
    endtask

    task automatic do_reset(input logic [15:0] m);
        reset       = 1'b1;
        matrix      = m;
        bus.key_ack = 1'b0;
        repeat (3) @(posedge clk_ctrl);
        @(negedge clk_ctrl);
        reset = 1'b0;
        model_reset();
    endtask

    // Wait for the commit cycle, optionally ack on its closing edge, then check the result
    task automatic commit_frame(input bit ack, input logic [15:0] next_m, input string tag);
        int n = 0;
        logic [15:0] cur;
        @(negedge clk_ctrl);
        while (bus.kb_col !== 4'hF && n < 40) begin
            @(negedge clk_ctrl);
            n++;
        end
        checks++;
        if (n >= 40) begin
            failures++;
            $display("FAIL %s commit_timeout: kb_col=%h never reached F", tag, bus.kb_col);
            return;
        end
        bus.key_ack = ack;
        cur         = matrix;
        matrix      = next_m;
        @(posedge clk_ctrl);
        #1;
        bus.key_ack = 1'b0;
        model_commit(cur, ack);
        checks++;
        if (bus.keys !== exp_keys) begin
            failures++;
            $display("FAIL %s keys: got %h expected %h", tag, bus.keys, exp_keys);
        end
        checks++;
        if (bus.key_valid !== exp_valid) begin
            failures++;
            $display("FAIL %s key_valid: got %b expected %b", tag, bus.key_valid, exp_valid);
        end
        checks++;
        if (bus.overrun !== exp_ovr) begin
            failures++;
            $display("FAIL %s overrun: got %b expected %b", tag, bus.overrun, exp_ovr);
        end
    endtask

    task automatic test_reset();
        reset  = 1'b1;
        matrix = 16'h0000;
        bus.key_ack = 1'b0;
        repeat (2) @(posedge clk_ctrl);
        #1;
        checks++;
        if (bus.kb_col !== 4'hE) begin
            failures++; $display("FAIL reset_kb_col: got %h expected e", bus.kb_col);
        end
        checks++;
        if (bus.keys !== 16'hFFFF) begin
            failures++; $display("FAIL reset_keys: got %h expected ffff", bus.keys);
        end
        checks++;
        if (bus.key_valid !== 1'b0 || bus.overrun !== 1'b0) begin
            failures++;
            $display("FAIL reset_flags: valid=%b overrun=%b expected 0 0", bus.key_valid, bus.overrun);
        end
    endtask

    task automatic test_idle_scan();
        int p;
        logic [3:0] e;
        int bad_out = 0;
        do_reset(16'hFFFF);
        for (int t = 0; t < 2 * FRAME_CYC; t++) begin
            p = t % FRAME_CYC;
            e = (p < 20) ? ~(4'b0001 << (p / 5)) : 4'hF;
            checks++;
            if (bus.kb_col !== e) begin
                failures++;
                $display("FAIL idle_kb_col cycle %0d: got %h expected %h", t, bus.kb_col, e);
            end
            if (bus.keys !== 16'hFFFF || bus.key_valid !== 1'b0) bad_out++;
            @(negedge clk_ctrl);
        end
        checks++;
        if (bad_out != 0) begin
            failures++;
            $display("FAIL idle_outputs: %0d cycles with keys/valid off idle, expected 0", bad_out);
        end
    endtask

    task automatic test_first_press();
        int n = 0;
        int hi = 0;
        do_reset(16'hFFFE);
        while (n < 200) begin
            @(posedge clk_ctrl);
            #1;
            n++;
            if (bus.key_valid === 1'b1) break;
        end
        checks++;
        if (n != FRAME_CYC * D_EFF) begin
            failures++;
            $display("FAIL first_press_latency: got %0d cycles expected %0d", n, FRAME_CYC * D_EFF);
        end
        checks++;
        if (bus.keys !== 16'hFFFE) begin
            failures++; $display("FAIL first_press_keys: got %h expected fffe", bus.keys);
        end
        @(negedge clk_ctrl);
        bus.key_ack = 1'b1;
        @(posedge clk_ctrl);
        #1;
        bus.key_ack = 1'b0;
        checks++;
        if (bus.key_valid !== 1'b0) begin
            failures++; $display("FAIL ack_clear: key_valid got %b expected 0", bus.key_valid);
        end
        repeat (3 * FRAME_CYC) begin
            @(posedge clk_ctrl);
            #1;
            if (bus.key_valid !== 1'b0) hi++;
        end
        checks++;
        if (hi != 0) begin
            failures++; $display("FAIL held_no_event: %0d cycles with key_valid, expected 0", hi);
        end
    endtask

    task automatic test_bounce();
        logic [15:0] seq[$];
        seq = '{16'hFFFE, 16'hFFFF, 16'hFFFE, 16'hFFFF,
                16'hFFFE, 16'hFFFE, 16'hFFFE, 16'hFFFE, 16'hFFFE};
        do_reset(seq[0]);
        for (int i = 0; i < seq.size(); i++)
            commit_frame(1'b0, (i + 1 < seq.size()) ? seq[i + 1] : seq[i], "bounce");
    endtask

    task automatic test_overrun();
        do_reset(16'hFDFF);
        for (int i = 0; i < 3; i++) commit_frame(1'b0, (i == 2) ? 16'hFFFF : 16'hFDFF, "ovr_press");
        for (int i = 0; i < 3; i++) commit_frame(1'b0, 16'hFFFF, "ovr_release");
        commit_frame(1'b1, 16'hFFFF, "ovr_ack");
        commit_frame(1'b1, 16'hFFFF, "ovr_idle_ack");
    endtask

    task automatic test_reset_mid();
        do_reset(16'hFFFE);
        for (int i = 0; i < D_EFF; i++) commit_frame(1'b0, 16'hFFFE, "mid_setup");
        repeat (4) @(posedge clk_ctrl);
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if (bus.keys !== 16'hFFFF || bus.key_valid !== 1'b0 || bus.kb_col !== 4'hE) begin
            failures++;
            $display("FAIL reset_mid: keys=%h valid=%b kb_col=%h expected ffff 0 e",
                     bus.keys, bus.key_valid, bus.kb_col);
        end
    endtask

    task automatic test_random();
        logic [15:0] q[$];
        logic [15:0] m;
        int run;
        for (int s = 0; s < 30; s++) begin
            case ($urandom_range(0, 3))
                0: m = 16'hFFFF;
                1: m = ~(16'h0001 << $urandom_range(0, 15));
                2: m = ~(16'h0001 << $urandom_range(0, 15)) & ~(16'h0001 << $urandom_range(0, 15));
                default: m = 16'($urandom);
            endcase
            run = $urandom_range(1, 4);
            repeat (run) q.push_back(m);
        end
        do_reset(q[0]);
        for (int i = 0; i < q.size(); i++)
            commit_frame($urandom_range(0, 2) == 0, (i + 1 < q.size()) ? q[i + 1] : q[i], "random");
    endtask

    initial begin
        test_reset();
        test_idle_scan();
        test_first_press();
        test_bounce();
        test_overrun();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
